// File: rtl/symbol_decision.sv
// symbol_decision: integrate-and-dump symbol slicer for Costas-loop I/Q baseband.
// Accepts a sample only when both I_tvalid and Q_tvalid are high. Integrates over
// SPS accepted samples and dumps when the sample counter equals sym_phase. The
// decided {b_I, b_Q} symbol is queued in a small AXI-Stream output FIFO.
// Optional feature: define SYMBOL_DECISION_LOCK_DETECT_EN to build the lock detector;
// without it, lock is tied low.
module symbol_decision #(
  parameter int DATA_WIDTH = 16,
  parameter int SPS        = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_32M768,
  input  logic                        rst_n_32M768,
  input  logic                        is_bpsk,
  input  logic [$clog2(SPS)-1:0]      sym_phase,
  input  logic signed [DATA_WIDTH-1:0] I_tdata,
  input  logic                        I_tvalid,
  input  logic signed [DATA_WIDTH-1:0] Q_tdata,
  input  logic                        Q_tvalid,
  output logic [1:0]                  bits_tdata,
  output logic                        bits_tvalid,
  input  logic                        bits_tready,
  output logic                        overflow,
  output logic                        lock
);

  localparam int PW = $clog2(SPS);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PW-1:0]                smp_cnt;
  logic signed [ACC_WIDTH-1:0]  i_acc, q_acc;
  logic signed [ACC_WIDTH-1:0]  i_ext, q_ext, i_sum, q_sum;
  logic                         accept, dump;
  logic [1:0]                   sym;

  logic [1:0]                   mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         full, pop, push, drop;

  // Sample qualification, running sums and the decided symbol at the dump point
  always_comb begin
    accept = I_tvalid & Q_tvalid;
    i_ext  = {{(ACC_WIDTH-DATA_WIDTH){I_tdata[DATA_WIDTH-1]}}, I_tdata};
    q_ext  = {{(ACC_WIDTH-DATA_WIDTH){Q_tdata[DATA_WIDTH-1]}}, Q_tdata};
    i_sum  = i_acc + i_ext;
    q_sum  = q_acc + q_ext;
    dump   = accept && (smp_cnt == sym_phase);
    sym    = {i_sum[ACC_WIDTH-1], is_bpsk ? 1'b0 : q_sum[ACC_WIDTH-1]};
  end

  // Sample counter and integrators; cleared on the dump edge
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      smp_cnt <= '0;
      i_acc   <= '0;
      q_acc   <= '0;
    end else if (accept) begin
      smp_cnt <= (smp_cnt == PW'(SPS-1)) ? '0 : smp_cnt + 1'b1;
      if (dump) begin
        i_acc <= '0;
        q_acc <= '0;
      end else begin
        i_acc <= i_sum;
        q_acc <= q_sum;
      end
    end
  end

  // FIFO control: a pop frees a slot in the same edge, so push-while-full is legal then
  always_comb begin
    full        = (count == CW'(FIFO_DEPTH));
    bits_tvalid = (count != '0);
    pop         = bits_tvalid && bits_tready;
    push        = dump && (!full || pop);
    drop        = dump && full && !pop;
    bits_tdata  = mem[rd_ptr];
  end

  // Symbol storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sym;
        wr_ptr      <= (wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef SYMBOL_DECISION_LOCK_DETECT_EN
  logic [ACC_WIDTH+1:0] i_abs, q_abs, mag_diff, mag_tot;
  logic                 good;
  logic [3:0]           lock_cnt, lock_cnt_nxt;

  // Per-dump quality metric and saturating lock counter step
  always_comb begin
    i_abs        = i_sum[ACC_WIDTH-1] ? (ACC_WIDTH+2)'(-i_sum) : (ACC_WIDTH+2)'(i_sum);
    q_abs        = q_sum[ACC_WIDTH-1] ? (ACC_WIDTH+2)'(-q_sum) : (ACC_WIDTH+2)'(q_sum);
    if (i_sum[ACC_WIDTH-1]) i_abs = (ACC_WIDTH+2)'(-{{2{i_sum[ACC_WIDTH-1]}}, i_sum});
    if (q_sum[ACC_WIDTH-1]) q_abs = (ACC_WIDTH+2)'(-{{2{q_sum[ACC_WIDTH-1]}}, q_sum});
    mag_diff     = (i_abs >= q_abs) ? i_abs - q_abs : q_abs - i_abs;
    mag_tot      = i_abs + q_abs;
    good         = is_bpsk ? (i_abs > (q_abs << 1)) : (mag_diff < (mag_tot >> 2));
    lock_cnt_nxt = lock_cnt;
    if (good && lock_cnt != 4'd15)
      lock_cnt_nxt = lock_cnt + 1'b1;
    else if (!good && lock_cnt != 4'd0)
      lock_cnt_nxt = lock_cnt - 1'b1;
  end

  // Lock with hysteresis: set on reaching 12, cleared on falling to 4
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (dump) begin
      lock_cnt <= lock_cnt_nxt;
      if (lock_cnt_nxt == 4'd12)
        lock <= 1'b1;
      else if (lock_cnt_nxt == 4'd4)
        lock <= 1'b0;
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule
